// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN pooling front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default pixel width, most-negative pad value, window generator state enum.
package cnn_pkg;

  localparam int DATA_SIZE = 16;

  // Most negative two's-complement value; a pad pixel can never win a max.
  localparam logic [DATA_SIZE-1:0] PIX_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    ROW_EVEN = 2'd0,
    ROW_ODD  = 2'd1,
    FLUSH    = 2'd2
  } win_state_t;

endpackage

// File: rtl/line_buffer.sv
// One-row pixel store holding the even row while the odd row streams past.
// Latency: write lands on the next clk edge; reads are combinational.
// Backpressure: none; writes only when we is high.
// Ports: clk, we/addr/wdata (synchronous write), rd_even/rd_odd (pixel pair around addr).
module line_buffer #(
  parameter int data_size = 16,
  parameter int depth     = 28,
  parameter int addr_w    = 5
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [addr_w-1:0]    addr,
  input  logic [data_size-1:0] wdata,
  output logic [data_size-1:0] rd_even,
  output logic [data_size-1:0] rd_odd
);

  // Rounded up to an even slot count so the odd half of the last pair of an
  // odd-width row is always an in-range location (its contents are never used).
  localparam int SLOTS = depth + (depth % 2);

  logic [data_size-1:0] mem [SLOTS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // For an odd addr these are mem[addr-1] and mem[addr]; for an even addr
  // they are the pair starting at addr, which is what the flush pass walks.
  assign rd_even = mem[addr & ~addr_w'(1)];
  assign rd_odd  = mem[addr |  addr_w'(1)];

endmodule

// File: rtl/pool_window_gen.sv
// Assembles non-overlapping 2x2 windows from a raster pixel stream for the max pooler.
// Latency: window_valid rises 1 cycle after the window's bottom-right pixel is accepted.
// Backpressure: in_ready is always 1, except 0 during the odd-height flush pass.
// Ports: clk, reset (sync, active high), pixel_in/pixel_valid/in_ready (input stream),
//        win_tl/win_tr/win_bl/win_br + window_valid (to pooler input1..4/enable), frame_done.
// Option: POOL_WIN_ODD_PAD_EN allows odd img_width/img_height, padding with the most negative value.
module pool_window_gen
  import cnn_pkg::*;
#(
  parameter int data_size  = DATA_SIZE,
  parameter int img_width  = 28,
  parameter int img_height = 28
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [data_size-1:0] pixel_in,
  input  logic                 pixel_valid,
  output logic                 in_ready,
  output logic [data_size-1:0] win_tl,
  output logic [data_size-1:0] win_tr,
  output logic [data_size-1:0] win_bl,
  output logic [data_size-1:0] win_br,
  output logic                 window_valid,
  output logic                 frame_done
);

  localparam int COL_W = $clog2(img_width);
  localparam int ROW_W = $clog2(img_height);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(img_width - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(img_height - 1);

  if (img_width < 2 || img_height < 2) begin : g_bad_dim
    $error("pool_window_gen: img_width and img_height must both be >= 2");
  end
`ifndef POOL_WIN_ODD_PAD_EN
  if ((img_width % 2) != 0 || (img_height % 2) != 0) begin : g_bad_odd
    $error("pool_window_gen: odd image dimensions need POOL_WIN_ODD_PAD_EN");
  end
`endif

  win_state_t           state, state_nxt;
  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  logic [data_size-1:0] bl_hold;
  logic [data_size-1:0] buf_even, buf_odd;
  logic                 accept, col_end, row_last;

  assign accept   = pixel_valid && in_ready;
  assign col_end  = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);

`ifdef POOL_WIN_ODD_PAD_EN
  localparam logic [data_size-1:0] PAD = {1'b1, {(data_size-1){1'b0}}};
  logic flush_last;
  // Last flush window once the pair starting at col reaches the row end.
  assign flush_last = ({1'b0, col} + (COL_W+1)'(2)) >= (COL_W+1)'(img_width);
  assign in_ready   = (state != FLUSH);
`else
  assign in_ready = 1'b1;
`endif

  line_buffer #(
    .data_size (data_size),
    .depth     (img_width),
    .addr_w    (COL_W)
  ) u_line_buf (
    .clk     (clk),
    .we      (accept && (state == ROW_EVEN)),
    .addr    (col),
    .wdata   (pixel_in),
    .rd_even (buf_even),
    .rd_odd  (buf_odd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ROW_EVEN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ROW_EVEN: begin
        if (accept && col_end) begin
`ifdef POOL_WIN_ODD_PAD_EN
          // An even row that is also the last row has no partner: flush it.
          state_nxt = row_last ? FLUSH : ROW_ODD;
`else
          state_nxt = ROW_ODD;
`endif
        end
      end
      ROW_ODD: begin
        if (accept && col_end) begin
          state_nxt = ROW_EVEN;
        end
      end
`ifdef POOL_WIN_ODD_PAD_EN
      FLUSH: begin
        if (flush_last) begin
          state_nxt = ROW_EVEN;
        end
      end
`endif
      default: state_nxt = ROW_EVEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col          <= '0;
      row          <= '0;
      bl_hold      <= '0;
      win_tl       <= '0;
      win_tr       <= '0;
      win_bl       <= '0;
      win_br       <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      if (accept) begin
        col <= col_end ? '0 : col + 1'b1;
        if (col_end) begin
          row <= row_last ? '0 : row + 1'b1;
        end
        if (state == ROW_ODD) begin
          if (col[0]) begin
            win_tl       <= buf_even;
            win_tr       <= buf_odd;
            win_bl       <= bl_hold;
            win_br       <= pixel_in;
            window_valid <= 1'b1;
            frame_done   <= col_end && row_last;
          end else begin
            bl_hold <= pixel_in;
`ifdef POOL_WIN_ODD_PAD_EN
            // Odd width: the lone last column forms a half-padded window.
            if (col_end) begin
              win_tl       <= buf_even;
              win_tr       <= PAD;
              win_bl       <= pixel_in;
              win_br       <= PAD;
              window_valid <= 1'b1;
              frame_done   <= row_last;
            end
`endif
          end
        end
      end
`ifdef POOL_WIN_ODD_PAD_EN
      // Flush walks the stored last row two columns per cycle, bottom padded.
      if (state == FLUSH) begin
        win_tl       <= buf_even;
        win_tr       <= col_end ? PAD : buf_odd;
        win_bl       <= PAD;
        win_br       <= PAD;
        window_valid <= 1'b1;
        frame_done   <= flush_last;
        col          <= flush_last ? '0 : col + COL_W'(2);
        if (flush_last) begin
          row <= '0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_pool_window_gen.sv
// Self-checking bench for pool_window_gen: 4x2 and 28x28 instances (plus 3x3 with POOL_WIN_ODD_PAD_EN).
// Latency: each driven cycle is checked 1 time unit after the clock edge that consumes it.
// Backpressure: in_ready is honoured by the reference model when deciding acceptance.
module tb_pool_window_gen;
  import cnn_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] pixel_in;
  logic        pixel_valid;
  int          sel;

  logic        pv_a  [3];
  logic        rdy_a [3];
  logic        vld_a [3];
  logic        fd_a  [3];
  logic [15:0] tl_a  [3];
  logic [15:0] tr_a  [3];
  logic [15:0] bl_a  [3];
  logic [15:0] br_a  [3];

  int errs   = 0;
  int checks = 0;
  int W, H, n;
  int img [0:27][0:27];
  int lw [4];
  int win_cnt, fd_cnt;
  int pmin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_pv
    assign pv_a[i] = pixel_valid && (sel == i);
  end

  pool_window_gen #(.data_size(16), .img_width(4), .img_height(2)) u_dut_s (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pv_a[0]), .in_ready(rdy_a[0]),
    .win_tl(tl_a[0]), .win_tr(tr_a[0]), .win_bl(bl_a[0]), .win_br(br_a[0]),
    .window_valid(vld_a[0]), .frame_done(fd_a[0]));

  pool_window_gen #(.data_size(16), .img_width(28), .img_height(28)) u_dut_l (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pv_a[1]), .in_ready(rdy_a[1]),
    .win_tl(tl_a[1]), .win_tr(tr_a[1]), .win_bl(bl_a[1]), .win_br(br_a[1]),
    .window_valid(vld_a[1]), .frame_done(fd_a[1]));

`ifdef POOL_WIN_ODD_PAD_EN
  pool_window_gen #(.data_size(16), .img_width(3), .img_height(3)) u_dut_o (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pv_a[2]), .in_ready(rdy_a[2]),
    .win_tl(tl_a[2]), .win_tr(tr_a[2]), .win_bl(bl_a[2]), .win_br(br_a[2]),
    .window_valid(vld_a[2]), .frame_done(fd_a[2]));
`else
  assign rdy_a[2] = 1'b1;
  assign vld_a[2] = 1'b0;
  assign fd_a[2]  = 1'b0;
  assign tl_a[2]  = '0;
  assign tr_a[2]  = '0;
  assign bl_a[2]  = '0;
  assign br_a[2]  = '0;
`endif

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rpix();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  task automatic check_win(input string tag);
    check({tag, "_tl"}, int'($signed(tl_a[sel])), lw[0]);
    check({tag, "_tr"}, int'($signed(tr_a[sel])), lw[1]);
    check({tag, "_bl"}, int'($signed(bl_a[sel])), lw[2]);
    check({tag, "_br"}, int'($signed(br_a[sel])), lw[3]);
  endtask

  // Called 1 time unit after the edge that accepted the frame's last pixel of an odd-height frame.
  task automatic flush_check();
    int nw;
    nw = (W + 1) / 2;
    pixel_valid = 1'b0;
    for (int k = 0; k < nw; k++) begin
      check("flush_in_ready", int'(rdy_a[sel]), 0);
      @(posedge clk); #1;
      lw[0] = img[H-1][2*k];
      lw[1] = (2*k + 1 < W) ? img[H-1][2*k+1] : pmin;
      lw[2] = pmin;
      lw[3] = pmin;
      check("flush_valid", int'(vld_a[sel]), 1);
      check("flush_frame_done", int'(fd_a[sel]), (k == nw - 1) ? 1 : 0);
      check_win("flush_win");
      if (vld_a[sel]) win_cnt++;
      if (fd_a[sel]) fd_cnt++;
    end
    check("flush_exit_in_ready", int'(rdy_a[sel]), 1);
  endtask

  // Called at a falling edge: offers one pixel, then checks the registered result.
  task automatic step(input bit v, input int p);
    bit acc, ev, ef, wrapped;
    int r, c;
    int ew [4];
    pixel_valid = v;
    pixel_in    = 16'(p);
    check("in_ready", int'(rdy_a[sel]), 1);
    acc = v && rdy_a[sel];
    ev = 1'b0; ef = 1'b0; wrapped = 1'b0;
    ew = '{0, 0, 0, 0};
    if (acc) begin
      r = n / W;
      c = n % W;
      img[r][c] = p;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        ev = 1'b1;
        ew = '{img[r-1][c-1], img[r-1][c], img[r][c-1], p};
      end else if ((r % 2 == 1) && (c == W - 1)) begin
        ev = 1'b1;
        ew = '{img[r-1][c], pmin, p, pmin};
      end
      ef = ev && (n == W * H - 1);
      wrapped = (n == W * H - 1);
      n = (n + 1) % (W * H);
    end
    @(posedge clk); #1;
    if (ev) lw = ew;
    check("window_valid", int'(vld_a[sel]), int'(ev));
    check("frame_done", int'(fd_a[sel]), int'(ef));
    check_win("win");
    if (vld_a[sel]) win_cnt++;
    if (fd_a[sel]) fd_cnt++;
    if (wrapped && (H % 2 == 1)) flush_check();
    @(negedge clk);
  endtask

  task automatic do_reset(input int s, input int w, input int h);
    sel = s; W = w; H = h;
    reset = 1'b1;
    pixel_valid = 1'b1;
    pixel_in = 16'($urandom);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n = 0;
    lw = '{0, 0, 0, 0};
    check("rst_window_valid", int'(vld_a[sel]), 0);
    check("rst_frame_done", int'(fd_a[sel]), 0);
    check("rst_in_ready", int'(rdy_a[sel]), 1);
    check_win("rst_win");
    reset = 1'b0;
    pixel_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int neg [8];
    int mx;
    reset = 1'b1;
    pixel_valid = 1'b0;
    pixel_in = '0;
    sel = 0;
    W = 4; H = 2; n = 0;
    win_cnt = 0; fd_cnt = 0;
    pmin = int'($signed(PIX_MIN));
    lw = '{0, 0, 0, 0};
    @(negedge clk);

    // 4x2 frame 1..8 back to back, then with valid toggling.
    do_reset(0, 4, 2);
    for (int i = 1; i <= 8; i++) step(1'b1, i);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, i);
      step(1'b0, 0);
    end

    // Negative data passes unchanged; max of the first window is -1.
    neg = '{-5, -1, 7, 9, -32768, -2, 3, 4};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, neg[i]);
      if (i == 5) begin
        mx = int'($signed(tl_a[0]));
        if (int'($signed(tr_a[0])) > mx) mx = int'($signed(tr_a[0]));
        if (int'($signed(bl_a[0])) > mx) mx = int'($signed(bl_a[0]));
        if (int'($signed(br_a[0])) > mx) mx = int'($signed(br_a[0]));
        check("pool_max", mx, -1);
      end
    end

    // Reset after pixel 5 discards the partial frame.
    for (int i = 1; i <= 5; i++) step(1'b1, i);
    do_reset(0, 4, 2);
    for (int i = 11; i <= 18; i++) step(1'b1, i);

    // Random pixels with random gaps.
    for (int i = 0; i < 48; i++) step(1'($urandom_range(0, 1)), rpix());

    // 28x28, two frames of random data with random stalls.
    do_reset(1, 28, 28);
    win_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < 2 * 28 * 28; i++) begin
      while ($urandom_range(0, 4) == 0) step(1'b0, rpix());
      step(1'b1, rpix());
    end
    check("windows_28x28", win_cnt, 2 * 196);
    check("frame_done_28x28", fd_cnt, 2);

`ifdef POOL_WIN_ODD_PAD_EN
    // 3x3 frame 1..9 with padding and flush, then a random frame.
    do_reset(2, 3, 3);
    win_cnt = 0; fd_cnt = 0;
    for (int i = 1; i <= 9; i++) step(1'b1, i);
    for (int i = 0; i < 9; i++) begin
      if ($urandom_range(0, 2) == 0) step(1'b0, rpix());
      step(1'b1, rpix());
    end
    check("windows_3x3", win_cnt, 8);
    check("frame_done_3x3", fd_cnt, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
